// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader: FSM states, skid depth
// and the circular-pointer helper used by the output buffer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 3;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, FIFO read-port and output-stream signals of the burst reader.
// slave = the reader itself, master = whoever drives commands, FIFO and sink.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5
);
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic             fifo_rd_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport slave (
        input  start, burst_len, fifo_empty, fifo_data, m_ready,
        output busy, done, fifo_rd_en, m_valid, m_data, m_last
    );

    modport master (
        output start, burst_len, fifo_empty, fifo_data, m_ready,
        input  busy, done, fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// 3-entry circular output buffer; a pushed entry is visible at the head next cycle.
// Never refuses a push: the reader only issues reads that are guaranteed a slot.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   occ
);
    logic [W-1:0] mem_q [SKID_DEPTH];
    logic [W-1:0] mem_d [SKID_DEPTH];
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign occ      = occ_q;
endmodule

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from a registered-output FIFO onto a valid/ready stream; first beat 3 cycles after start.
// Reads are credit-limited by buffer occupancy plus the in-flight word, so m_ready never feeds fifo_rd_en.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    fifo_burst_reader_if.slave bus
);
    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic             inflight_q, inflight_d;
    logic             infl_last_q, infl_last_d;
    logic             rd_en;
    logic             m_valid;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       outstanding;
    entry_t           head;
    entry_t           push_entry;

    assign outstanding = {1'b0, occ} + {2'b00, inflight_q};
    assign m_valid     = (occ != 2'd0);
    assign pop         = m_valid && bus.m_ready;
    assign push_entry  = '{last: infl_last_q, data: bus.fifo_data};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        rd_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.burst_len != '0) begin
                        state_d  = BURST;
                        len_d    = bus.burst_len;
                        issued_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BURST: begin
                rd_en = !bus.fifo_empty && (issued_q < len_q) && (outstanding < 3'(SKID_DEPTH));
                if (rd_en) begin
                    issued_d = issued_q + 1'b1;
                end
                // The last tag travels with the data, so completion is seen at the stream side.
                if (pop && head.last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        inflight_d  = rd_en;
        infl_last_d = (issued_q == len_q - 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
        end
    end

    rd_skid_buf #(
        .W(WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head),
        .occ      (occ)
    );

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = head.data;
    assign bus.m_last     = head.last;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized scoreboard bench: a queue-based FIFO model feeds the reader, and a
// negedge monitor checks every beat against the words queued for the burst.
module tb_fifo_burst_reader;
    localparam int WIDTH = 8;
    localparam int LEN_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nreads = 0;
    int nbeats = 0;
    int done_cnt = 0;
    int beat_cyc[$];
    int done_cyc[$];

    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] push_q[$];
    logic [WIDTH-1:0] pend_q[$];
    logic [WIDTH-1:0] fifo_word;
    logic             rd_sample;
    logic             prev_stall = 1'b0;
    logic [WIDTH:0]   prev_out = '0;
    logic [WIDTH:0]   exp_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered data one cycle after an accepted read.
    always @(negedge clk) rd_sample <= bus.fifo_rd_en && !bus.fifo_empty;

    always @(posedge clk) begin
        if (rd_sample === 1'b1 && fifo_q.size() > 0) begin
            fifo_word = fifo_q.pop_front();
            bus.fifo_data <= fifo_word;
        end
        while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_rd_en) begin
                nreads++;
                check("rd_while_empty", bus.fifo_empty, 0);
                check("outstanding_le3", (nreads - nbeats) <= 3, 1);
            end
            if (prev_stall && bus.m_valid)
                check("stall_hold", {bus.m_last, bus.m_data}, prev_out);
            if (bus.m_valid && bus.m_ready) begin
                nbeats++;
                beat_cyc.push_back(cyc);
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check("beat", {bus.m_last, bus.m_data}, exp_beat);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_out   = {bus.m_last, bus.m_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    bus.busy, 0);
        check({tag, "_done"},    bus.done, 0);
        check({tag, "_rd_en"},   bus.fifo_rd_en, 0);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_data"},  bus.m_data, 0);
        check({tag, "_m_last"},  bus.m_last, 0);
    endtask

    task automatic begin_burst(input int len, input int pre, input int extra,
                               input bit seq, output int t0);
        logic [WIDTH-1:0] w;
        exp_q.delete();
        pend_q.delete();
        beat_cyc.delete();
        done_cyc.delete();
        nreads = 0;
        nbeats = 0;
        for (int i = 0; i < len; i++) begin
            w = seq ? WIDTH'(8'h11 * (i + 1)) : WIDTH'($urandom);
            exp_q.push_back({(i == len - 1), w});
            if (i < pre) push_q.push_back(w);
            else         pend_q.push_back(w);
        end
        for (int i = 0; i < extra; i++) begin
            w = WIDTH'($urandom);
            if (pend_q.size() == 0) push_q.push_back(w);
            else                    pend_q.push_back(w);
        end
        bus.start     = 1'b1;
        bus.burst_len = LEN_W'(len);
        t0 = cyc;
    endtask

    task automatic run_burst(input int len, input int pre, input int extra,
                             input int ready_pct, input int hold,
                             input int fill_delay, input int fill_pct,
                             input bit repulse, input bit seq, output int t0);
        int d0;
        int rel;
        bit seen;
        d0 = done_cnt;
        begin_burst(len, pre, extra, seq, t0);
        bus.m_ready = (hold == 0) && ($urandom_range(0, 99) < ready_pct);
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            bus.start     = 1'b0;
            bus.burst_len = LEN_W'($urandom);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
            rel = cyc - t0;
            if (repulse && $urandom_range(0, 3) == 0) bus.start = 1'b1;
            bus.m_ready = (rel >= hold) && ($urandom_range(0, 99) < ready_pct);
            if (hold > 0 && rel == hold) check("reads_during_hold", nreads, 3);
            if (rel >= fill_delay) begin
                if (fill_pct >= 100) begin
                    while (pend_q.size() > 0) push_q.push_back(pend_q.pop_front());
                end else if (pend_q.size() > 0 && $urandom_range(0, 99) < fill_pct) begin
                    push_q.push_back(pend_q.pop_front());
                end
            end
        end
        check("done_seen", seen, 1);
        check("done_pulses", done_cnt - d0, 1);
        check("beat_count", nbeats, len);
        check("read_count", nreads, len);
        check("exp_drained", exp_q.size(), 0);
        check("busy_after", bus.busy, 0);
        check("fifo_leftover", fifo_q.size() + push_q.size() + pend_q.size(), extra);
        fifo_q.delete();
        push_q.delete();
        pend_q.delete();
        bus.m_ready = 1'b0;
    endtask

    initial begin
        int t0;
        int d0;
        int len;
        bus.start     = 1'b0;
        bus.burst_len = '0;
        bus.m_ready   = 1'b0;
        rst = 1'b1;
        step();
        step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Directed 4-word burst with fixed latency and throughput.
        run_burst(4, 4, 2, 100, 0, 0, 100, 1'b0, 1'b1, t0);
        for (int i = 0; i < beat_cyc.size(); i++) check("b4_beat_cycle", beat_cyc[i], t0 + 3 + i);
        if (done_cyc.size() > 0) check("b4_done_cycle", done_cyc[0], t0 + 7);

        // Zero-length burst.
        run_burst(0, 0, 2, 100, 0, 0, 100, 1'b0, 1'b0, t0);
        if (done_cyc.size() > 0) check("b0_done_cycle", done_cyc[0], t0 + 1);

        // Back-pressure for 10 cycles.
        run_burst(8, 8, 1, 100, 10, 0, 100, 1'b0, 1'b0, t0);

        // FIFO runs dry after 2 words, refilled later.
        run_burst(5, 2, 1, 100, 0, 8, 100, 1'b0, 1'b0, t0);

        // Reset during the second beat of a 6-word burst.
        begin_burst(6, 6, 0, 1'b0, t0);
        bus.m_ready = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        push_q.delete();
        pend_q.delete();
        bus.m_ready = 1'b0;
        step();
        step();
        step();
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", bus.busy, 0);
        run_burst(1, 1, 0, 100, 0, 0, 100, 1'b0, 1'b0, t0);

        // Start re-pulsed while busy.
        run_burst(7, 7, 2, 60, 0, 0, 100, 1'b1, 1'b0, t0);

        // Randomized bursts.
        for (int b = 0; b < 12; b++) begin
            len = $urandom_range(0, 31);
            run_burst(len, $urandom_range(0, len), $urandom_range(0, 3),
                      $urandom_range(30, 100), 0, $urandom_range(0, 10),
                      $urandom_range(20, 100), 1'($urandom_range(0, 1)), 1'b0, t0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
